// File: rtl/bram_seq_pkg.sv
// rtl/bram_seq_pkg.sv - shared types and constants for the BRAM cascade run controller
// Purpose: state enumeration, DUT reset length and a log2 width helper.
// Ports: none (package).
package bram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUT_RST,
    STAGGER,
    SETTLE,
    RUN,
    DONE
  } state_t;

  localparam int DUT_RST_CYC = 2;

  // Bits needed to index n items; never less than 1.
  function automatic int log2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bram_seq_prio_enc.sv
// rtl/bram_seq_prio_enc.sv - lowest-set-bit priority encoder
// Purpose: reports the index of the lowest asserted request bit.
// Ports:
//   req   in  N  request vector
//   idx   out W  index of lowest set bit (0 when none)
//   valid out 1  at least one request bit set
module bram_seq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_cascade_seq.sv
// rtl/bram_cascade_seq.sv - staggered start / run-window controller for cascaded-BRAM test DUTs
// Purpose: resets the DUT array, enables instances one at a time, waits a settle
// window, then accumulates per-instance pass flags over a fixed run window.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, abort      sequence control (abort wins over start)
//   dut_rst           reset to all DUTs
//   dut_start         per-DUT start, thermometer filled bit 0 first
//   dut_enable        per-DUT enable, mirrors dut_start
//   dut_pass          per-DUT pass flags
//   busy, done        sequence status
//   pass_all          no DUT failed (meaningful while done)
//   fail_vec          sticky per-DUT failure flags
//   first_fail_id     lowest-index DUT of the first failing cycle
//   first_fail_cyc    run-window index of the first failure
module bram_cascade_seq
  import bram_seq_pkg::*;
#(
  parameter int N_DUT       = 8,
  parameter int STAGGER_CYC = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int RUN_CYC     = 1024,
  parameter int CNT_W       = 16,
  localparam int ID_W       = log2w(N_DUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             dut_rst,
  output logic [N_DUT-1:0] dut_start,
  output logic [N_DUT-1:0] dut_enable,
  input  logic [N_DUT-1:0] dut_pass,
  output logic             busy,
  output logic             done,
  output logic             pass_all,
  output logic [N_DUT-1:0] fail_vec,
  output logic [ID_W-1:0]  first_fail_id,
  output logic [CNT_W-1:0] first_fail_cyc
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  if (N_DUT < 2 || STAGGER_CYC < 1 || SETTLE_CYC < 1 || RUN_CYC < 1 ||
      longint'(STAGGER_CYC) > CNT_MAX || longint'(SETTLE_CYC) > CNT_MAX ||
      longint'(RUN_CYC) > CNT_MAX ||
      longint'((N_DUT - 1) * STAGGER_CYC) > CNT_MAX) begin : g_param_check
    $error("bram_cascade_seq: parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(DUT_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST   = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(RUN_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             dut_rst_n, busy_n, done_n, pass_all_n;
  logic [N_DUT-1:0] dut_start_n, fail_vec_n, fail_now, fail_acc;
  logic [ID_W-1:0]  ffid_n, enc_idx;
  logic [CNT_W-1:0] ffcyc_n;
  logic             enc_valid;

  assign fail_now = ~dut_pass;
  assign fail_acc = fail_vec | fail_now;

  bram_seq_prio_enc #(
    .N (N_DUT),
    .W (ID_W)
  ) u_prio_enc (
    .req   (fail_now),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      dut_rst        <= 1'b0;
      dut_start      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_all       <= 1'b0;
      fail_vec       <= '0;
      first_fail_id  <= '0;
      first_fail_cyc <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      dut_rst        <= dut_rst_n;
      dut_start      <= dut_start_n;
      busy           <= busy_n;
      done           <= done_n;
      pass_all       <= pass_all_n;
      fail_vec       <= fail_vec_n;
      first_fail_id  <= ffid_n;
      first_fail_cyc <= ffcyc_n;
    end
  end

  assign dut_enable = dut_start;

  // One counter is shared by every timed state: it is cleared on each state
  // entry. In STAGGER it counts the phase within one stagger slot and the
  // thermometer shifts in a 1 at the end of each slot, so bit i becomes
  // visible exactly i*STAGGER_CYC cycles into the state.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dut_rst_n   = dut_rst;
    dut_start_n = dut_start;
    busy_n      = busy;
    done_n      = done;
    pass_all_n  = pass_all;
    fail_vec_n  = fail_vec;
    ffid_n      = first_fail_id;
    ffcyc_n     = first_fail_cyc;

    if (abort && state != IDLE) begin
      // Failure record is left intact so it can be inspected after abort.
      state_n     = IDLE;
      cnt_n       = '0;
      dut_rst_n   = 1'b0;
      dut_start_n = '0;
      busy_n      = 1'b0;
      done_n      = 1'b0;
      pass_all_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_n     = DUT_RST;
            cnt_n       = '0;
            dut_rst_n   = 1'b1;
            dut_start_n = '0;
            busy_n      = 1'b1;
            done_n      = 1'b0;
            pass_all_n  = 1'b0;
            fail_vec_n  = '0;
            ffid_n      = '0;
            ffcyc_n     = '0;
          end
        end
        DUT_RST: begin
          if (cnt == RST_LAST) begin
            state_n     = STAGGER;
            cnt_n       = '0;
            dut_rst_n   = 1'b0;
            dut_start_n = N_DUT'(1);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STAGGER: begin
          if (dut_start[N_DUT-1]) begin
            state_n = SETTLE;
            cnt_n   = '0;
          end else if (cnt == STAG_LAST) begin
            cnt_n       = '0;
            dut_start_n = {dut_start[N_DUT-2:0], 1'b1};
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RUN: begin
          fail_vec_n = fail_acc;
          // An all-zero fail_vec means no earlier run cycle has failed.
          if (fail_vec == '0 && enc_valid) begin
            ffid_n  = enc_idx;
            ffcyc_n = cnt;
          end
          if (cnt == RUN_LAST) begin
            state_n     = DONE;
            cnt_n       = '0;
            dut_start_n = '0;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            // Include this cycle's sample so pass_all agrees with fail_vec.
            pass_all_n  = ~|fail_acc;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_cascade_seq.sv
// tb/tb_bram_cascade_seq.sv - scoreboard bench for bram_cascade_seq
module tb_bram_cascade_seq;

  localparam int N   = 4;
  localparam int STG = 4;
  localparam int STL = 8;
  localparam int RN  = 16;
  localparam int CW  = 16;
  // Offsets (in posedges after the edge that samples start) at which things
  // become visible: dut_start[i] at 2+i*STG, RUN index r samples dut_pass
  // driven while 23+r, done at 39.
  localparam int REL_SETTLE = 2 + (N - 1) * STG + 1;
  localparam int REL_RUN    = REL_SETTLE + STL;
  localparam int REL_DONE   = REL_RUN + RN;

  typedef struct {
    int          due;
    logic        pa;
    logic [N-1:0] fv;
    int          id;
    int          fc;
  } exp_t;

  typedef struct {
    int bit_i;
    int due;
  } rise_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dut_rst;
  logic [N-1:0]  dut_start, dut_enable, dut_pass, fail_vec;
  logic          busy, done, pass_all;
  logic [1:0]    first_fail_id;
  logic [CW-1:0] first_fail_cyc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t  done_q[$];
  rise_t rise_q[$];
  logic [N-1:0] run_pat[RN];
  logic [N-1:0] settle_pat;

  bram_cascade_seq #(
    .N_DUT       (N),
    .STAGGER_CYC (STG),
    .SETTLE_CYC  (STL),
    .RUN_CYC     (RN),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .dut_rst        (dut_rst),
    .dut_start      (dut_start),
    .dut_enable     (dut_enable),
    .dut_pass       (dut_pass),
    .busy           (busy),
    .done           (done),
    .pass_all       (pass_all),
    .fail_vec       (fail_vec),
    .first_fail_id  (first_fail_id),
    .first_fail_cyc (first_fail_cyc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: the verdict over the first nr run indices of run_pat.
  task automatic model(input int nr, output exp_t e);
    logic [N-1:0] bad;
    e.pa = 1'b1;
    e.fv = '0;
    e.id = 0;
    e.fc = 0;
    e.due = 0;
    for (int r = 0; r < nr; r++) begin
      bad = ~run_pat[r];
      if (bad != 0 && e.fv == 0) begin
        e.fc = r;
        for (int b = N - 1; b >= 0; b--) if (bad[b]) e.id = b;
      end
      e.fv = e.fv | bad;
    end
    e.pa = (e.fv == 0);
  endtask

  function automatic logic [N-1:0] pat_for(input int rel);
    if (rel >= REL_RUN && rel < REL_DONE) return run_pat[rel - REL_RUN];
    if (rel >= REL_SETTLE && rel < REL_RUN) return settle_pat;
    return '1;
  endfunction

  // Inputs change 1 time unit after the falling edge, after the monitor samples.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_dut_rst", dut_rst, 0);
    chk("rst_dut_start", dut_start, 0);
    chk("rst_dut_enable", dut_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass_all", pass_all, 0);
    chk("rst_fail_vec", fail_vec, 0);
    chk("rst_first_fail_id", first_fail_id, 0);
    chk("rst_first_fail_cyc", first_fail_cyc, 0);
  endtask

  // abort_r >= 0: abort while RUN index abort_r is current.
  // rst_rel >= 0: assert rst that many cycles after start was sampled.
  task automatic do_seq(input int abort_r, input bit poke_start, input int rst_rel);
    exp_t e;
    int t;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    t = cyc;
    if (abort_r < 0 && rst_rel < 0) begin
      model(RN, e);
      e.due = t + REL_DONE;
      done_q.push_back(e);
    end
    for (int i = 0; i < N; i++) rise_q.push_back('{i, t + 2 + i * STG});
    for (int rel = 0; rel <= REL_DONE + 3; rel++) begin
      if (rel > 0) step();
      if (rel == 0) chk("seq_dut_rst", dut_rst, 1);
      if (rel == 2) begin
        chk("seq_fail_vec_cleared", fail_vec, 0);
        chk("seq_busy", busy, 1);
      end
      dut_pass = pat_for(rel);
      start = poke_start && (rel == 10 || rel == REL_RUN + 7);
      if (abort_r >= 0 && rel == REL_RUN + abort_r) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        model(abort_r, e);
        chk("abort_dut_start", dut_start, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_fail_vec_held", fail_vec, e.fv);
        chk("abort_ffid_held", first_fail_id, e.id);
        chk("abort_ffcyc_held", first_fail_cyc, e.fc);
        dut_pass = '1;
        repeat (REL_DONE) step();
        chk("abort_stay_idle", busy, 0);
        return;
      end
      if (rst_rel >= 0 && rel == rst_rel) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals();
        rise_q.delete();
        return;
      end
    end
    start = 1'b0;
  endtask

  // Monitor: compares DUT events against the scoreboard queues.
  logic [N-1:0] prev_start = '0;
  logic         prev_done = 1'b0;
  always @(negedge clk) begin
    logic [N-1:0] rising;
    exp_t  e;
    rise_t r;
    rising = dut_start & ~prev_start;
    for (int i = 0; i < N; i++) begin
      if (rising[i]) begin
        if (rise_q.size() == 0) begin
          chk("unexpected_rise_bit", i, 32'hFFFF);
        end else begin
          r = rise_q.pop_front();
          chk("rise_bit", i, r.bit_i);
          chk("rise_cyc", cyc, r.due);
          chk("enable_eq_start", dut_enable, dut_start);
        end
      end
    end
    if (done && !prev_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 0, 1);
      end else begin
        e = done_q.pop_front();
        chk("done_cyc", cyc, e.due);
        chk("pass_all", pass_all, e.pa);
        chk("fail_vec", fail_vec, e.fv);
        chk("first_fail_id", first_fail_id, e.id);
        chk("first_fail_cyc", first_fail_cyc, e.fc);
        chk("done_dut_start", dut_start, 0);
      end
    end
    prev_start = dut_start;
    prev_done  = done;
  end

  task automatic clear_pats();
    for (int r = 0; r < RN; r++) run_pat[r] = '1;
    settle_pat = '1;
  endtask

  task automatic rand_pats();
    clear_pats();
    for (int r = 0; r < RN; r++)
      if ($urandom_range(0, 7) == 0) run_pat[r] = N'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench timed out at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    dut_pass = '1;
    repeat (2) step();
    rst = 1'b0;
    check_reset_vals();

    clear_pats();
    do_seq(-1, 1'b0, -1);              // nominal pass

    clear_pats();
    run_pat[5] = 4'b1011;
    do_seq(-1, 1'b0, -1);              // single late failure

    clear_pats();
    run_pat[0] = 4'b0101;
    do_seq(-1, 1'b0, -1);              // simultaneous failures at index 0

    clear_pats();
    settle_pat = '0;
    run_pat[RN-1] = 4'b0111;           // last run index still counts
    do_seq(-1, 1'b0, -1);

    clear_pats();
    settle_pat = '0;
    do_seq(-1, 1'b0, -1);              // failures ignored in SETTLE

    rand_pats();
    do_seq(-1, 1'b1, -1);              // start while busy

    clear_pats();
    run_pat[1] = 4'b1110;
    do_seq(3, 1'b0, -1);               // abort at run index 3

    rand_pats();
    run_pat[2] = 4'b0111;
    do_seq(-1, 1'b0, -1);              // restart after abort

    clear_pats();
    do_seq(-1, 1'b0, 8);               // rst mid-STAGGER

    for (int k = 0; k < 4; k++) begin
      rand_pats();
      do_seq(-1, 1'b0, -1);
    end

    repeat (3) step();
    chk("done_q_drained", done_q.size(), 0);
    chk("rise_q_drained", rise_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
